san_counter_axil_slave: RTL

- AXI4-Lite slave (responder) register file for the san_counter IP.
- It is the target that the master VIP / PS master drives with single-beat writes and reads.
- Holds four 32-bit R/W registers and an up-counter controlled by those registers; the live count is readable over the bus.
- Sits behind the interconnect on the S00_AXI port of the san_counter block.

---
 rtl/san_counter_axil_slave.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/san_counter_axil_slave.sv
// AXI4-Lite register slave for the san_counter IP.
// Holds CTRL/LIMIT/SCRATCH0/SCRATCH1, an up-counter driven by CTRL/LIMIT,
// and a read-only view of the live count.
// Optional build macro: SAN_COUNTER_IRQ_EN adds a sticky STATUS register at
// 0x14 and a registered irq output.
//
// Counter mode (implicit, derived from CTRL, no state register):
//   mode | meaning
//   IDLE | CTRL.enable = 0, count holds (or clears while CTRL.clear = 1)
//   RUN  | CTRL.enable = 1, count increments and wraps to 0 after LIMIT
module san_counter_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       count_out,
  output logic                              count_wrap
`ifdef SAN_COUNTER_IRQ_EN
  ,
  output logic                              irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_LIMIT    = 3'd1;
  localparam logic [2:0] IDX_SCRATCH0 = 3'd2;
  localparam logic [2:0] IDX_SCRATCH1 = 3'd3;
  localparam logic [2:0] IDX_COUNT    = 3'd4;
`ifdef SAN_COUNTER_IRQ_EN
  localparam logic [2:0] IDX_STATUS   = 3'd5;
`endif

  // readies are held low until the first cycle after reset is released
  logic          ready_en_q;

  logic          aw_full_q;
  logic [2:0]    aw_idx_q;
  logic          w_full_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;

  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;

  logic [31:0]   ctrl_q;
  logic [31:0]   limit_q;
  logic [31:0]   scratch0_q;
  logic [31:0]   scratch1_q;
  logic [31:0]   count_q;
  logic          wrap_q;
`ifdef SAN_COUNTER_IRQ_EN
  logic          status_q;
  logic          irq_q;
`endif

  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          wr_fire;
  logic          wr_ok;
  logic [2:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;

  // byte offset bits and protection fields carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ready_en_q && !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = ready_en_q && !w_full_q && !bvalid_q;
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign count_out     = count_q;
  assign count_wrap    = wrap_q;
`ifdef SAN_COUNTER_IRQ_EN
  assign irq           = irq_q;
`endif

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs  = bvalid_q && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = rvalid_q && S_AXI_RREADY;

  // a write commits on the edge where both halves are available, either
  // from the capture buffers or from a handshake happening this cycle
  assign wr_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[4:2];
  assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;
  assign wr_fire = !bvalid_q && (aw_full_q || aw_hs) && (w_full_q || w_hs);

`ifdef SAN_COUNTER_IRQ_EN
  assign wr_ok = (wr_idx <= IDX_SCRATCH1) || (wr_idx == IDX_STATUS);
`else
  assign wr_ok = (wr_idx <= IDX_SCRATCH1);
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // enable the ready outputs one cycle after reset deasserts
  always_ff @(posedge ACLK) begin
    if (ARESET) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // write channel: AW/W capture buffers and B response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  // register file update on write commit; COUNT and unmapped slots ignore writes
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_q     <= '0;
      limit_q    <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
    end else if (wr_fire) begin
      case (wr_idx)
        IDX_CTRL:     ctrl_q     <= merge_bytes(ctrl_q,     wr_data, wr_strb);
        IDX_LIMIT:    limit_q    <= merge_bytes(limit_q,    wr_data, wr_strb);
        IDX_SCRATCH0: scratch0_q <= merge_bytes(scratch0_q, wr_data, wr_strb);
        IDX_SCRATCH1: scratch1_q <= merge_bytes(scratch1_q, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  // read data mux from the current register contents
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (S_AXI_ARADDR[4:2])
      IDX_CTRL:     rd_data = ctrl_q;
      IDX_LIMIT:    rd_data = limit_q;
      IDX_SCRATCH0: rd_data = scratch0_q;
      IDX_SCRATCH1: rd_data = scratch1_q;
      IDX_COUNT:    rd_data = count_q;
`ifdef SAN_COUNTER_IRQ_EN
      IDX_STATUS:   rd_data = {31'd0, status_q};
`endif
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  // read channel: capture data at AR handshake, hold until R handshake
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  // counter: clear has priority, then wrap at LIMIT, else increment while enabled
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (ctrl_q[1]) begin
        count_q <= '0;
      end else if (ctrl_q[0]) begin
        if (count_q == limit_q) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q + 32'd1;
        end
      end
    end
  end

`ifdef SAN_COUNTER_IRQ_EN
  // sticky wrap status (set beats a simultaneous clear) and registered irq
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      status_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wrap_q)
        status_q <= 1'b1;
      else if (wr_fire && wr_idx == IDX_STATUS && wr_strb[0] && wr_data[0])
        status_q <= 1'b0;
      irq_q <= status_q & ctrl_q[2];
    end
  end
`endif

endmodule
